switch_port_drain: RTL and testbench
====================================

Name: switch_port_drain

Overview:
- Downstream consumer of the switch egress side.
- Monitors the per-port ready flags and grants one port at a time, round-robin, via its read strobe.
- Captures the byte stream the port emits while the switch read-out flag is high, then re-emits it on one framed output stream (sop/eop/port tag) through an internal FIFO with valid/ready backpressure.
- Sits between the switch and the single egress link/serialiser.

Parameters:
- NUM_OF_PORTS, 4, number of switch ports served; port index width PW = clog2(NUM_OF_PORTS), minimum 1.
- WORD_WIDTH, 8, data byte width.
- OUT_FIFO_SIZE, 64, output FIFO depth in entries; power of 2, must be >= MAX_PKT.
- MAX_PKT, 64, largest packet in bytes; a grant is issued only if at least MAX_PKT entries are free.
- TIMEOUT, 16, cycles allowed between grant and first read_out.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-high (asserted = 1).
- port_ready  in  NUM_OF_PORTS  per-port "packet available" flags from the switch.
- port_out  in  NUM_OF_PORTS*WORD_WIDTH  packed port data; port k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
- read_out  in  1  high while the granted port drives a valid byte.
- port_read  out  NUM_OF_PORTS  one-hot read strobe to the granted port.
- out_data  out  WORD_WIDTH  FIFO head byte.
- out_sop  out  1  head byte is the first byte of a packet.
- out_eop  out  1  head byte is the last byte of a packet.
- out_port  out  PW  source port of the head byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head byte when out_valid && out_ready.
- busy  out  1  FSM not in IDLE.
- timeout_cnt  out  8  saturating count of grant timeouts.

Behaviour:
- Reset (rst_n=1 at a clk edge): FSM goes to IDLE, port_read=0, rr_ptr=0, FIFO emptied, out_valid=0, out_sop/out_eop/out_data/out_port=0, busy=0, timeout_cnt=0, hold register invalid. Reset mid-transfer discards any partial packet. Nothing already popped is affected.
- IDLE:
  - Grant when the set of ready ports is non-zero AND free entries >= MAX_PKT.
  - The granted port is the first ready port at or after rr_ptr, searching upward with wrap.
  - Latch gnt and go to WAIT. port_read[gnt] rises the cycle after the decision.
- WAIT:
  - port_read[gnt]=1; wait counter increments each cycle.
  - read_out=1 -> capture port_out[gnt] into the hold register with sop=1; go to XFER.
  - Counter reaches TIMEOUT with no read_out -> drop port_read, increment timeout_cnt (saturate at 255), set rr_ptr=gnt+1 mod NUM_OF_PORTS, return to IDLE.
- XFER:
  - port_read[gnt] stays 1.
  - Each cycle with read_out=1: push the held byte (sop as held, eop=0) into the FIFO and load the new byte into hold with sop=0.
  - First cycle with read_out=0: go to FLUSH and drop port_read.
  - A packet longer than MAX_PKT is a protocol violation; bytes are still pushed, and a push while the FIFO is full is dropped.
- FLUSH:
  - Push the held byte with eop=1; a single-byte packet gets sop=1 and eop=1 on the same entry.
  - Set rr_ptr=gnt+1 mod NUM_OF_PORTS; return to IDLE.
  - The earliest next grant decision is the following cycle.
- Latency: the first byte reaches the FIFO 1 cycle after its read_out cycle. out_valid rises the cycle after the push.
- FIFO:
  - Synchronous, entry = {port, sop, eop, data}.
  - Push and pop in the same cycle are allowed at any fill level except a push into a full FIFO without a pop.
  - Pop from empty is ignored.
  - Output fields are stable while out_valid && !out_ready.
- port_read is never multi-hot; port_read=0 in IDLE.

Test Plan:
- Single packet: port_ready=4'b0100, read_out high 3 cycles with bytes A1,A2,A3 -> port_read=4'b0100; FIFO emits {A1 sop},{A2},{A3 eop} with out_port=2; rr_ptr=3.
- Round-robin: all ports ready, each sends 2 bytes -> grant order 0,1,2,3,0; no port repeats while another is ready.
- Backpressure: out_ready=0 while 60 bytes are buffered, port 1 ready -> no grant (free entries < 64); after 60 pops, port_read[1] asserts.
- Timeout: port 3 ready, read_out never rises -> port_read[3] drops after 16 cycles, timeout_cnt=1, next grant goes to port 0.
- Single-byte packet: read_out high 1 cycle, data 5A -> one entry with sop=1, eop=1, data=5A.
- Reset mid-XFER: assert rst_n after 2 of 4 bytes -> out_valid=0, port_read=0, busy=0 next cycle; a subsequent packet emits cleanly with sop.

Source files
------------

// File: rtl/switch_port_drain.sv
// Drains switch egress ports round-robin into one framed (sop/eop/port) byte stream.
// Latency: a byte is pushed into the output FIFO one cycle after it is held; out_valid follows the push by one cycle.
// Backpressure: out_ready stalls the FIFO head; a new grant is issued only when MAX_PKT entries are free.
module switch_port_drain #(
  parameter int NUM_OF_PORTS  = 4,
  parameter int WORD_WIDTH    = 8,
  parameter int OUT_FIFO_SIZE = 64,
  parameter int MAX_PKT       = 64,
  parameter int TIMEOUT       = 16,
  localparam int PW = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_OF_PORTS-1:0]            port_ready,
  input  logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_out,
  input  logic                               read_out,
  output logic [NUM_OF_PORTS-1:0]            port_read,
  output logic [WORD_WIDTH-1:0]              out_data,
  output logic                               out_sop,
  output logic                               out_eop,
  output logic [PW-1:0]                      out_port,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic [7:0]                         timeout_cnt
);

  localparam int AW = (OUT_FIFO_SIZE > 1) ? $clog2(OUT_FIFO_SIZE) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = PW + 2 + WORD_WIDTH;

  localparam logic [CW-1:0] FULL_LVL  = CW'(OUT_FIFO_SIZE);
  localparam logic [CW-1:0] GRANT_LVL = CW'(OUT_FIFO_SIZE - MAX_PKT);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_OF_PORTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_FLUSH} state_t;

  state_t                  state_q;
  logic [PW-1:0]           gnt_q;
  logic [PW-1:0]           rr_q;
  logic [NUM_OF_PORTS-1:0] port_read_q;
  logic [TW-1:0]           wait_q;
  logic [7:0]              to_cnt_q;
  logic [WORD_WIDTH-1:0]   hold_data_q;
  logic                    hold_sop_q;
  logic                    hold_vld_q;

  logic [EW-1:0]           mem_q [OUT_FIFO_SIZE];
  logic [AW-1:0]           wr_q;
  logic [AW-1:0]           rd_q;
  logic [CW-1:0]           cnt_q;

  logic [PW-1:0]           pick_d;
  logic                    found_d;
  logic [NUM_OF_PORTS-1:0] gnt_oh_d;
  logic [PW-1:0]           next_ptr_d;
  logic [WORD_WIDTH-1:0]   sel_byte_d;
  logic                    room_d;
  logic                    push_req_d;
  logic                    push_ok_d;
  logic                    pop_d;
  logic                    full_d;
  logic [EW-1:0]           push_dat_d;
  logic [EW-1:0]           head_d;

  // Round-robin pick: first ready port at or above rr_q, wrapping around.
  always_comb begin
    int idx;
    idx      = 0;
    pick_d   = rr_q;
    found_d  = 1'b0;
    gnt_oh_d = '0;
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_OF_PORTS) idx = idx - NUM_OF_PORTS;
      if (!found_d && port_ready[PW'(idx)]) begin
        found_d = 1'b1;
        pick_d  = PW'(idx);
      end
    end
    gnt_oh_d[pick_d] = 1'b1;
  end

  assign next_ptr_d = (gnt_q == LAST_PORT) ? '0 : gnt_q + 1'b1;
  assign sel_byte_d = port_out[gnt_q*WORD_WIDTH +: WORD_WIDTH];
  assign room_d     = (cnt_q <= GRANT_LVL);

  // The held byte goes out when a successor arrives (not last) or in FLUSH (last).
  assign push_req_d = hold_vld_q && (((state_q == S_XFER) && read_out) || (state_q == S_FLUSH));
  assign push_dat_d = {gnt_q, hold_sop_q, (state_q == S_FLUSH), hold_data_q};

  assign full_d    = (cnt_q == FULL_LVL);
  assign pop_d     = (cnt_q != '0) && out_ready;
  assign push_ok_d = push_req_d && (!full_d || pop_d);

  // Grant / wait / transfer / flush sequencing with registered strobe and counters.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      rr_q        <= '0;
      port_read_q <= '0;
      wait_q      <= '0;
      to_cnt_q    <= '0;
      hold_data_q <= '0;
      hold_sop_q  <= 1'b0;
      hold_vld_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          hold_vld_q <= 1'b0;
          if (found_d && room_d) begin
            gnt_q       <= pick_d;
            port_read_q <= gnt_oh_d;
            wait_q      <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (read_out) begin
            hold_data_q <= sel_byte_d;
            hold_sop_q  <= 1'b1;
            hold_vld_q  <= 1'b1;
            state_q     <= S_XFER;
          end else if (wait_q == TO_LAST) begin
            port_read_q <= '0;
            if (to_cnt_q != 8'hFF) to_cnt_q <= to_cnt_q + 8'd1;
            rr_q        <= next_ptr_d;
            state_q     <= S_IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_XFER: begin
          if (read_out) begin
            hold_data_q <= sel_byte_d;
            hold_sop_q  <= 1'b0;
          end else begin
            port_read_q <= '0;
            state_q     <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          hold_vld_q <= 1'b0;
          rr_q       <= next_ptr_d;
          state_q    <= S_IDLE;
        end
        default: begin
          port_read_q <= '0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; not reset, the head is masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (!rst_n && push_ok_d) mem_q[wr_q] <= push_dat_d;
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok_d) wr_q <= wr_q + 1'b1;
      if (pop_d)     rd_q <= rd_q + 1'b1;
      case ({push_ok_d, pop_d})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_d      = mem_q[rd_q];
  assign out_valid   = (cnt_q != '0);
  assign {out_port, out_sop, out_eop, out_data} = out_valid ? head_d : '0;
  assign port_read   = port_read_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_cnt = to_cnt_q;

endmodule

// File: tb/tb_switch_port_drain.sv
// Directed bench for switch_port_drain with a scoreboard of expected output entries.
// Stimulus steps run in one initial block; a negedge monitor compares the FIFO head.
// Every wait on the DUT is bounded by a cycle budget.
module tb_switch_port_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  port_ready;
  logic [31:0] port_out;
  logic        read_out;
  logic [3:0]  port_read;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_port;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [7:0]  timeout_cnt;

  typedef struct packed {
    logic [1:0] port;
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } ent_t;

  ent_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  switch_port_drain dut (
    .clk        (clk),
    .rst_n      (rst),
    .port_ready (port_ready),
    .port_out   (port_out),
    .read_out   (read_out),
    .port_read  (port_read),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .timeout_cnt(timeout_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: head must match the scoreboard front; a handshake pops it.
  always @(negedge clk) begin
    if (!rst) begin
      chk("port_read_onehot0", 32'($onehot0(port_read)), 1);
      if (!busy) chk("idle_no_read", port_read, 0);
      if (out_valid && out_ready) chk("pop_expected", 32'(exp_q.size() != 0), 1);
      if (out_valid && exp_q.size() != 0) begin
        chk("head", {out_port, out_sop, out_eop, out_data}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_grant(input int p);
    int n = 0;
    logic [3:0] e;
    e = 4'b0001 << p;
    while (port_read === 4'b0000 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("grant", port_read, e);
  endtask

  task automatic send(input int p, input int n, input logic [7:0] base);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      read_out = 1'b1;
      port_out[p*8 +: 8] = base + 8'(i);
      e.port = 2'(p);
      e.sop  = (i == 0);
      e.eop  = (i == n - 1);
      e.data = base + 8'(i);
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    read_out = 1'b0;
    port_ready[p] = 1'b0;
    @(posedge clk); #1;
    chk("read_drop", port_read, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
    chk("fifo_empty", out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b1;
    port_ready = '0;
    port_out   = '0;
    read_out   = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_port_read", port_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_cnt", timeout_cnt, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sop", out_sop, 0);
    chk("rst_eop", out_eop, 0);
    chk("rst_port", out_port, 0);
    rst = 1'b0;

    // Single packet from port 2.
    port_ready = 4'b0100;
    wait_grant(2);
    send(2, 3, 8'hA1);
    wait_drain();

    // Pointer now at 3: with ports 0,1,3 ready, port 3 wins.
    port_ready = 4'b1011;
    wait_grant(3);
    send(3, 2, 8'hB0);
    port_ready = 4'b1111;

    // Round robin 0,1,2,3,0 with port 0 re-requesting.
    wait_grant(0);
    send(0, 2, 8'hC0);
    port_ready[0] = 1'b1;
    wait_grant(1);
    send(1, 2, 8'hC4);
    wait_grant(2);
    send(2, 2, 8'hC8);
    wait_grant(3);
    send(3, 2, 8'hCC);
    wait_grant(0);
    send(0, 2, 8'hD0);
    wait_drain();

    // Single-byte packet.
    port_ready = 4'b0010;
    wait_grant(1);
    send(1, 1, 8'h5A);
    wait_drain();

    // Backpressure: 60 bytes stuck in the FIFO block any new grant.
    out_ready  = 1'b0;
    port_ready = 4'b0001;
    wait_grant(0);
    send(0, 60, 8'h10);
    port_ready = 4'b0010;
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("bp_no_grant", port_read, 0);
    chk("bp_idle", busy, 0);
    chk("bp_level", exp_q.size(), 60);
    out_ready = 1'b1;
    wait_grant(1);
    chk("bp_grant_after_drain", exp_q.size(), 0);
    send(1, 2, 8'h80);
    wait_drain();

    // Timeout on port 3, then the pointer has moved on to port 0.
    port_ready = 4'b1000;
    wait_grant(3);
    n = 0;
    while (port_read[3] === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_cycles", n, 16);
    chk("timeout_cnt", timeout_cnt, 1);
    chk("timeout_idle", busy, 0);
    port_ready = 4'b1001;
    wait_grant(0);
    port_ready[3] = 1'b0;
    send(0, 1, 8'h33);
    wait_drain();

    // Reset in the middle of a transfer discards the partial packet.
    port_ready = 4'b0100;
    wait_grant(2);
    out_ready = 1'b0;
    read_out  = 1'b1;
    port_out[23:16] = 8'hD0;
    @(posedge clk); #1;
    port_out[23:16] = 8'hD1;
    @(posedge clk); #1;
    chk("pre_reset_valid", out_valid, 1);
    rst        = 1'b1;
    read_out   = 1'b0;
    port_ready = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_port_read", port_read, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_timeout_cnt", timeout_cnt, 0);
    out_ready  = 1'b1;
    port_ready = 4'b0100;
    wait_grant(2);
    send(2, 3, 8'hE0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
